// File: rtl/q_flop_sequencer.sv
// Shares one q_flop sampler among N_REQ requesters: round-robin grant, arm, wait for ack, respond.
// Optional QSEQ_ERR_COUNT_EN adds a saturating timeout counter (err_count_o) with synchronous clear.
module q_flop_sequencer #(
    parameter int N_REQ       = 4,
    parameter int ARM_CYCLES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  qf_sel_o,
    output logic             qf_rst_o,
    input  logic             qf_ack_i,
    input  logic             qf_out_i,
    output logic             rsp_valid_o,
    output logic [ID_W-1:0]  rsp_id_o,
    output logic             rsp_bit_o,
    output logic             rsp_err_o
`ifdef QSEQ_ERR_COUNT_EN
    ,
    input  logic             err_clr_i,
    output logic [7:0]       err_count_o
`endif
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST    = ARM_W'(ARM_CYCLES - 1);
    localparam logic [7:0]       SYNC_CNT    = 8'(SYNC_STAGES);
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  sel_q, sel_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             qf_rst_q, qf_rst_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic             rsp_err_q, rsp_err_d;

    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] out_sync_q;
    logic                   ack_s;
    logic                   out_s;

    // qf_ack/qf_out are asynchronous to clk; only the last stage is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
            out_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], qf_ack_i};
            out_sync_q <= {out_sync_q[SYNC_STAGES-2:0], qf_out_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign out_s = out_sync_q[SYNC_STAGES-1];

    // Requests at or above the pointer win; otherwise fall back to the lowest set bit (wrap).
    logic [N_REQ-1:0] req_hi;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  pick_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign req_hi[gi] = req_i[gi] & (ID_W'(gi) >= ptr_q);
        end
    endgenerate

    always_comb begin
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                pick = ID_W'(k);
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_hi[k]) begin
                pick = ID_W'(k);
            end
        end
        pick_next = (pick == LAST_ID) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            arm_cnt_q   <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            qf_rst_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            arm_cnt_q   <= arm_cnt_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            qf_rst_q    <= qf_rst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        arm_cnt_d   = arm_cnt_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        qf_rst_d    = qf_rst_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_bit_d   = rsp_bit_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                qf_rst_d = 1'b1;
                if (|req_i) begin
                    gnt_d     = N_REQ'(1'b1) << pick;
                    sel_d     = pick;
                    ptr_d     = pick_next;
                    arm_cnt_d = '0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                // qf_rst stays high while the external data mux settles on the new select.
                qf_rst_d = 1'b1;
                if (arm_cnt_q == ARM_LAST) begin
                    cnt_d    = '0;
                    qf_rst_d = 1'b0;
                    state_d  = ST_WAIT;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                qf_rst_d = 1'b0;
                // The first SYNC_STAGES cycles may still show an ack left over from before release.
                if ((cnt_q >= SYNC_CNT) && ack_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    rsp_bit_d   = out_s;
                    rsp_err_d   = 1'b0;
                    qf_rst_d    = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    rsp_bit_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    qf_rst_d    = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q < TIMEOUT_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                qf_rst_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                qf_rst_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign qf_sel_o    = sel_q;
    assign qf_rst_o    = qf_rst_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_bit_o   = rsp_bit_q;
    assign rsp_err_o   = rsp_err_q;

`ifdef QSEQ_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Clear has priority over a coincident timeout strobe.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr_i) begin
            err_count_d = 8'd0;
        end else if (rsp_valid_q && rsp_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;
`endif

endmodule
